bcd_seg_display: RTL
====================

Name: bcd_seg_display

Overview:
- Downstream output stage for board-level test tops: consumes the result word produced by a compiled test module, e.g. the out0/out_valid/out_ready side of tests_fibl.
- Converts the word to decimal with an iterative double-dabble FSM.
- Drives a 4-digit multiplexed, active-low 7-segment display with leading-zero blanking and an overflow indication.

Parameters:
- N, 16: input word width (`intN); 16 is the only width required to be supported.
- REFRESH_BITS, 17: width of the free-running refresh counter; per-digit dwell is 2^(REFRESH_BITS-2) cycles.

Ports:
- clk  input  1  system clock, all logic on posedge.
- nrst  input  1  synchronous active-low reset.
- in_valid  input  1  upstream result valid (connects to out_valid of the producing module).
- in_ready  output  1  block can accept a value (connects to out_ready of the producer).
- in0  input  N  unsigned result word.
- seg  output  7  segment cathodes, active-low, seg[6:0] = g,f,e,d,c,b,a.
- dp  output  1  decimal point, active-low, held 1 (off).
- an  output  4  digit anodes, active-low, an[0] = rightmost digit.

Behaviour:
- Single clock domain. Reset is synchronous, active-low, on nrst==0 at posedge clk.
- Reset values:
  - state=IDLE, in_ready=1, refresh counter=0.
  - Displayed BCD digits = 0, overflow flag = 0.
  - an=4'b1110, seg = pattern "0", dp=1.
- FSM states: IDLE, CONVERT, SHOW.
  - IDLE/SHOW: in_ready=1. On in_valid && in_ready:
    - latch in0 into a shift register, clear the 20-bit BCD accumulator and the iteration counter;
    - latch ovf = (in0 > 9999);
    - go to CONVERT.
  - CONVERT: in_ready=0. Each cycle:
    - every BCD nibble >= 5 gets +3;
    - then {bcd,shift} shifts left by one;
    - iteration counter increments.
    - After exactly N iterations, copy the low 4 BCD nibbles and ovf to the display registers and go to SHOW.
    - in_valid is ignored while in CONVERT; the producer must hold its value, since out_ready is low.
- Latency:
  - A value accepted at edge T appears on the display registers after edge T+N (T+16 for N=16).
  - in_ready is high again in the cycle after edge T+N, so back-to-back accepts are N+1 cycles apart.
- The display registers change only at the end of CONVERT; the previous value stays displayed throughout conversion.
- Refresh:
  - counter increments every cycle, wraps freely, and is never reset by data activity.
  - digit index d = counter[REFRESH_BITS-1:REFRESH_BITS-2]; an = ~(4'b0001 << d).
  - seg follows the selected digit registered (one cycle after index change) or combinationally; either is acceptable, but an and seg must be consistent within the same cycle.
- Digit patterns (seg[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, dash=0111111.
- Leading-zero blanking: digit i>0 shows blank if it and all more significant digits are 0. Digit 0 always shows its value, so 0 displays "   0".
- Overflow: if ovf=1, all four digits show dash ("----"), regardless of BCD content.
- Reset mid-CONVERT: aborts the conversion, no display update, returns to reset state.
- Input values 0..65535 must all convert without corruption. The 5th BCD nibble exists internally but is never displayed.

Test Plan:
- Bench uses REFRESH_BITS=4.
  1. Reset: hold nrst=0 for 3 cycles, release -> in_ready=1; an steps 1110,1101,1011,0111 every 4 cycles; seg=1000000 when an=1110, 1111111 otherwise.
  2. Accept 1234: pulse in_valid with in0=16'd1234 at edge T:
     - in_ready=0 for cycles T+1..T+16, 1 at T+17;
     - then an=1110->seg 0011001 (4), 1101->0110000 (3), 1011->0100100 (2), 0111->1111001 (1).
  3. Blanking: send 7, then 0 -> "   7", then "   0"; digits 1..3 blank. Send 9999 -> all four show 0010000.
  4. Overflow: send 10000, then 65535 -> all digits 0111111. Send 42 -> "  42" restored.
  5. Handshake: hold in_valid=1 with in0=5 then change to 6 during CONVERT -> only 5 captured; 6 accepted at the first in_ready=1 edge; display ends at "   6".
  6. Reset mid-conversion: accept 8888, drop nrst at T+8 for one cycle -> display "   0", in_ready=1 next cycle, no later update to 8888.

Source files
------------

// File: rtl/bcd_seg_display.sv
// Result word -> 4-digit active-low 7-segment display via a serial double-dabble FSM.
// Conversion takes N cycles after accept; in_ready stays low during it, the previous value stays shown.
module bcd_seg_display #(
  parameter int N            = 16,
  parameter int REFRESH_BITS = 17
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in0,
  output logic [6:0]   seg,
  output logic         dp,
  output logic [3:0]   an
);

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

  localparam int CW = $clog2(N + 1);

  state_t                  state;
  logic [N-1:0]            shift;
  logic [19:0]             bcd;
  logic [CW-1:0]           iter;
  logic                    ovf;
  logic                    ovf_disp;
  logic [15:0]             digits;
  logic [REFRESH_BITS-1:0] refresh;

  logic [19:0]  bcd_adj;
  logic [19:0]  bcd_next;
  logic [N-1:0] shift_next;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign {bcd_next, shift_next} = {bcd_adj, shift} << 1;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      shift    <= '0;
      bcd      <= '0;
      iter     <= '0;
      ovf      <= 1'b0;
      ovf_disp <= 1'b0;
      digits   <= '0;
    end else begin
      case (state)
        IDLE, SHOW: begin
          if (in_valid && in_ready) begin
            shift    <= in0;
            bcd      <= '0;
            iter     <= '0;
            ovf      <= (in0 > N'(9999));
            in_ready <= 1'b0;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          bcd   <= bcd_next;
          shift <= shift_next;
          iter  <= iter + 1'b1;
          // Last iteration: publish the post-shift result directly.
          if (iter == CW'(N - 1)) begin
            digits   <= bcd_next[15:0];
            ovf_disp <= ovf;
            in_ready <= 1'b1;
            state    <= SHOW;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      refresh <= '0;
    end else begin
      refresh <= refresh + 1'b1;
    end
  end

  logic [1:0] sel;
  logic [3:0] nib;
  logic       blank;
  logic       z3, z2, z1;

  assign sel = refresh[REFRESH_BITS-1 -: 2];
  assign z3  = (digits[15:12] == 4'd0);
  assign z2  = z3 && (digits[11:8] == 4'd0);
  assign z1  = z2 && (digits[7:4] == 4'd0);

  always_comb begin
    nib   = digits[3:0];
    blank = 1'b0;
    case (sel)
      2'd0: begin nib = digits[3:0];   blank = 1'b0; end
      2'd1: begin nib = digits[7:4];   blank = z1;   end
      2'd2: begin nib = digits[11:8];  blank = z2;   end
      2'd3: begin nib = digits[15:12]; blank = z3;   end
      default: ;
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    if (ovf_disp) begin
      seg = 7'b0111111;
    end else if (!blank) begin
      case (nib)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

  assign an = ~(4'b0001 << sel);
  assign dp = 1'b1;

endmodule
